// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: exception codes,
// stall vectors, FSM states and the priority/target decode helpers.
package pipeline_ctrl_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    // bit 0 = PC ... bit 5 = WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EXC_WAIT = 2'd1,
        ST_GAP      = 2'd2
    } ctrl_state_t;

    function automatic logic [5:0] stall_prio(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

    function automatic logic [31:0] exc_target(input logic [31:0] code, input logic [31:0] epc,
                                               input logic [31:0] vec);
        case (code)
            EXC_ERET:                                  return epc;
            EXC_INT, EXC_SYS, EXC_RI, EXC_OV, EXC_TR:  return vec;
            default:                                   return vec;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges stall requests, turns
// MEM-stage exceptions into a flush + redirect, deferring it across I-cache refills.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          FLUSH_GAP  = 1,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_state_t state;
    logic [1:0]  gap_cnt;
    logic [31:0] tgt_q;
    logic        exc_now;
    logic [31:0] tgt_now;
    logic [5:0]  prio;

    assign exc_now = (excepttype != 32'd0);
    assign tgt_now = exc_target(excepttype, cp0_epc, EXC_VECTOR);
    assign prio    = stall_prio(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);

    // Outputs are combinational so the flush reaches MEM2WB in the detecting cycle.
    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = 32'd0;
        if (rst) begin
            case (state)
                ST_RUN: begin
                    if (exc_now && !stallreq_if) begin
                        flush  = 1'b1;
                        new_pc = tgt_now;
                    end else if (exc_now) begin
                        stall = STALL_ALL;
                    end else begin
                        stall = prio;
                    end
                end
                ST_EXC_WAIT: begin
                    if (!stallreq_if) begin
                        flush  = 1'b1;
                        new_pc = tgt_q;
                    end else begin
                        stall = STALL_ALL;
                    end
                end
                default: stall = prio;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_RUN;
            gap_cnt <= 2'd0;
            tgt_q   <= 32'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (exc_now && !stallreq_if) begin
                        state   <= ST_GAP;
                        gap_cnt <= 2'd0;
                    end else if (exc_now) begin
                        state <= ST_EXC_WAIT;
                        tgt_q <= tgt_now;
                    end
                end
                ST_EXC_WAIT: begin
                    if (!stallreq_if) begin
                        state   <= ST_GAP;
                        gap_cnt <= 2'd0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 2'(FLUSH_GAP - 1))
                        state <= ST_RUN;
                    else
                        gap_cnt <= gap_cnt + 2'd1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall[0]),
        .cnt (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush),
        .cnt (flush_count)
    );

endmodule
